// File: rtl/arm_hazard_pkg.sv
// Shared defaults and helpers for the register-scoreboard hazard detector.
package arm_hazard_pkg;

   localparam int unsigned DEF_REG_ADDR_W  = 4;
   localparam int unsigned DEF_NUM_SRC     = 3;
   localparam int unsigned DEF_CNT_W       = 3;
   localparam int unsigned DEF_WB_DIST     = 2;
   localparam int unsigned DEF_ALU_FWD_LAT = 0;
   localparam int unsigned DEF_LD_FWD_LAT  = 1;
   localparam int unsigned DEF_PERF_W      = 32;

   typedef logic [DEF_CNT_W-1:0] cnt_t;

   // Cycles until a consumer in ID may read the result of an instruction issued now.
   function automatic int unsigned issue_latency(input logic        with_fwd,
                                                 input logic        is_load,
                                                 input int unsigned wb_dist,
                                                 input int unsigned alu_lat,
                                                 input int unsigned ld_lat);
      if (!with_fwd) begin
         return wb_dist;
      end
      if (is_load) begin
         return ld_lat;
      end
      return alu_lat;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage side of the hazard scoreboard: instruction descriptor in, stall out.
interface hazard_scoreboard_unit_if
   import arm_hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int unsigned NUM_SRC    = DEF_NUM_SRC
);

   logic                           with_forwarding;
   logic                           id_valid;
   logic                           ignore_hazard;
   logic                           flush;
   logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr;
   logic [NUM_SRC-1:0]             src_used;
   logic [REG_ADDR_W-1:0]          dest_addr;
   logic                           wb_en;
   logic                           mem_read_en;
   logic                           hazard_detected;
   logic [NUM_SRC-1:0]             src_hazard;

   // ID stage drives the descriptor and receives the stall.
   modport master (
      output with_forwarding, id_valid, ignore_hazard, flush, src_addr, src_used,
             dest_addr, wb_en, mem_read_en,
      input  hazard_detected, src_hazard
   );

   // Scoreboard consumes the descriptor and produces the stall.
   modport slave (
      input  with_forwarding, id_valid, ignore_hazard, flush, src_addr, src_used,
             dest_addr, wb_en, mem_read_en,
      output hazard_detected, src_hazard
   );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown of cycles until this register's value is consumable.
module hazard_sb_entry #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;

   // A new producer reloads (newest write wins); otherwise count down to zero and hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard that stalls the ID stage on RAW hazards.
module hazard_scoreboard_unit
   import arm_hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
   parameter int unsigned NUM_SRC     = DEF_NUM_SRC,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned WB_DIST     = DEF_WB_DIST,
   parameter int unsigned ALU_FWD_LAT = DEF_ALU_FWD_LAT,
   parameter int unsigned LD_FWD_LAT  = DEF_LD_FWD_LAT,
   parameter int unsigned PERF_W      = DEF_PERF_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   hazard_scoreboard_unit_if.slave  id_bus,
   input  logic                     perf_clr,
   output logic [PERF_W-1:0]        stall_cycles
);

   localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

   logic [CNT_W-1:0]      cnt [NUM_REGS];
   logic [NUM_REGS-1:0]   load_vec;
   logic [REG_ADDR_W-1:0] src_a [NUM_SRC];
   logic [NUM_SRC-1:0]    src_hz;
   logic [CNT_W-1:0]      lat;
   logic                  hazard;
   logic                  issue;
   logic [PERF_W-1:0]     stall_q;

   // A source is blocked while its producer's counter is still running; counters are read
   // pre-issue, so an instruction never waits on its own destination.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign src_a[i]  = id_bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      assign src_hz[i] = id_bus.id_valid & id_bus.src_used[i] & ~id_bus.ignore_hazard &
                         (cnt[src_a[i]] != '0);
   end

   // Flush squashes the ID instruction, so it neither stalls nor issues.
   assign hazard = (|src_hz) & ~id_bus.flush;
   assign issue  = id_bus.id_valid & ~hazard & ~id_bus.flush;

   // Latency is chosen by the mode at issue time; running counters are unaffected by mode changes.
   assign lat = CNT_W'(issue_latency(id_bus.with_forwarding, id_bus.mem_read_en,
                                     WB_DIST, ALU_FWD_LAT, LD_FWD_LAT));

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
      assign load_vec[r] = issue & id_bus.wb_en & (id_bus.dest_addr == REG_ADDR_W'(r));

      hazard_sb_entry #(
         .CNT_W (CNT_W)
      ) u_entry (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load_vec[r]),
         .load_val (lat),
         .cnt      (cnt[r])
      );
   end

   // Saturating stall-cycle counter; a clear in the same cycle beats the increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (perf_clr) begin
         stall_q <= '0;
      end else if (hazard && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign id_bus.hazard_detected = hazard;
   assign id_bus.src_hazard      = src_hz;
   assign stall_cycles           = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench: default scoreboard (dut0) and a slow-load, narrow-perf variant (dut1) fed the same
// instruction stream, checked against a ready-time model of register availability.
module tb_hazard_scoreboard_unit;

   logic        clk;
   logic        rst_n;
   logic        perf_clr;
   logic [31:0] stall0;
   logic [3:0]  stall1;

   int vectors     = 0;
   int miscompares = 0;

   // Model: cycle index at which each register becomes readable in ID.
   longint cyc;
   longint ready_at [2][16];
   longint stall_m  [2];
   longint stall_max[2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
   int     ld_lat   [2] = '{1, 3};

   logic       last_hz [2];
   logic [2:0] last_src0;
   logic [31:0] last_stall0;

   hazard_scoreboard_unit_if #(.REG_ADDR_W(4), .NUM_SRC(3)) if0 ();
   hazard_scoreboard_unit_if #(.REG_ADDR_W(4), .NUM_SRC(3)) if1 ();

   hazard_scoreboard_unit dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_bus       (if0.slave),
      .perf_clr     (perf_clr),
      .stall_cycles (stall0)
   );

   hazard_scoreboard_unit #(
      .LD_FWD_LAT (3),
      .PERF_W     (4)
   ) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_bus       (if1.slave),
      .perf_clr     (perf_clr),
      .stall_cycles (stall1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, ign, fl, fwd, we, ld, input logic [3:0] d, s0, s1, s2,
                        input logic [2:0] used, input logic pc);
      if0.id_valid = v;   if1.id_valid = v;
      if0.ignore_hazard = ign; if1.ignore_hazard = ign;
      if0.flush = fl;     if1.flush = fl;
      if0.with_forwarding = fwd; if1.with_forwarding = fwd;
      if0.wb_en = we;     if1.wb_en = we;
      if0.mem_read_en = ld; if1.mem_read_en = ld;
      if0.dest_addr = d;  if1.dest_addr = d;
      if0.src_addr = {s2, s1, s0}; if1.src_addr = {s2, s1, s0};
      if0.src_used = used; if1.src_used = used;
      perf_clr = pc;
   endtask

   // One ID cycle: drive, check combinational outputs, advance model, check counters after edge.
   task automatic step(input logic v, ign, fl, fwd, we, ld, input logic [3:0] d, s0, s1, s2,
                       input logic [2:0] used, input logic pc);
      logic [3:0] s [3];
      @(negedge clk);
      drive(v, ign, fl, fwd, we, ld, d, s0, s1, s2, used, pc);
      #1;
      s = '{s0, s1, s2};
      for (int k = 0; k < 2; k++) begin
         logic [2:0]  esrc;
         logic        ehz;
         longint      lat;
         esrc = '0;
         for (int i = 0; i < 3; i++) begin
            if (v && used[i] && !ign && (cyc < ready_at[k][s[i]])) esrc[i] = 1'b1;
         end
         ehz = (esrc != 3'b000) && !fl;
         chk($sformatf("src_hazard%0d", k), (k == 0) ? if0.src_hazard : if1.src_hazard, esrc);
         chk($sformatf("hazard%0d", k),
             (k == 0) ? if0.hazard_detected : if1.hazard_detected, ehz);
         last_hz[k] = (k == 0) ? if0.hazard_detected : if1.hazard_detected;
         if (v && !ehz && !fl && we) begin
            lat = !fwd ? 2 : (ld ? ld_lat[k] : 0);
            ready_at[k][d] = cyc + 1 + lat;
         end
         if (pc) stall_m[k] = 0;
         else if (ehz && (stall_m[k] != stall_max[k])) stall_m[k]++;
      end
      last_src0 = if0.src_hazard;
      @(posedge clk);
      #1;
      cyc++;
      chk("stall_cycles0", 64'(stall0), 64'(stall_m[0]));
      chk("stall_cycles1", 64'(stall1), 64'(stall_m[1]));
      last_stall0 = stall0;
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
   endtask

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin
         stall_m[k] = 0;
         for (int r = 0; r < 16; r++) ready_at[k][r] = 0;
      end
   endtask

   // Drop reset asynchronously mid-cycle while a reader of r4 sits in ID.
   task automatic async_reset();
      @(negedge clk);
      drive(1, 0, 0, 1, 0, 0, 0, 4, 0, 0, 3'b001, 0);
      #2 rst_n = 1'b0;
      #1;
      clear_model();
      chk("rst_stall0", 64'(stall0), 64'd0);
      chk("rst_stall1", 64'(stall1), 64'd0);
      chk("rst_hz0", 64'(if0.hazard_detected), 64'd0);
      chk("rst_hz1", 64'(if1.hazard_detected), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      cyc   = 0;
      clear_model();
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      #3;
      chk("reset_stall0", 64'(stall0), 64'd0);
      chk("reset_hz0", 64'(if0.hazard_detected), 64'd0);
      chk("reset_src0", 64'(if0.src_hazard), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Load-use with forwarding: one stall cycle.
      step(1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 3'b000, 0);
      step(1, 0, 0, 1, 1, 0, 4, 3, 0, 0, 3'b001, 0);
      chk("t1_stall", 64'(last_hz[0]), 64'd1);
      step(1, 0, 0, 1, 1, 0, 4, 3, 0, 0, 3'b001, 0);
      chk("t1_issue", 64'(last_hz[0]), 64'd0);
      chk("t1_stall_cycles", 64'(last_stall0), 64'd1);
      idle(4);

      // ALU-use: no stall with forwarding, two stalls without.
      step(1, 0, 0, 1, 1, 0, 3, 0, 0, 0, 3'b000, 0);
      step(1, 0, 0, 1, 1, 0, 5, 0, 3, 0, 3'b010, 0);
      chk("t2_fwd_nostall", 64'(last_hz[0]), 64'd0);
      idle(3);
      step(1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 3'b000, 0);
      step(1, 0, 0, 0, 1, 0, 5, 0, 0, 3, 3'b100, 0);
      chk("t2_nofwd_stall_a", 64'(last_hz[0]), 64'd1);
      step(1, 0, 0, 0, 1, 0, 5, 0, 0, 3, 3'b100, 0);
      chk("t2_nofwd_stall_b", 64'(last_hz[0]), 64'd1);
      step(1, 0, 0, 0, 1, 0, 5, 0, 0, 3, 3'b100, 0);
      chk("t2_nofwd_issue", 64'(last_hz[0]), 64'd0);
      idle(4);

      // Three-cycle load on dut1.
      step(1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 3'b000, 0);
      for (int j = 0; j < 3; j++) begin
         step(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 3'b001, 0);
         chk("t3_ld3_stall", 64'(last_hz[1]), 64'd1);
      end
      step(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 3'b001, 0);
      chk("t3_ld3_issue", 64'(last_hz[1]), 64'd0);
      idle(4);
      step(1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 3'b000, 0);
      step(1, 0, 0, 1, 0, 0, 0, 6, 0, 0, 3'b001, 0);
      chk("t3_other_reg", 64'(last_hz[1]), 64'd0);
      idle(4);

      // WAW: ALU write overrides an in-flight load countdown.
      step(1, 0, 0, 1, 1, 1, 2, 0, 0, 0, 3'b000, 0);
      step(1, 0, 0, 1, 1, 0, 2, 0, 0, 0, 3'b000, 0);
      step(1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 3'b001, 0);
      chk("t4_waw_hz0", 64'(last_hz[0]), 64'd0);
      chk("t4_waw_hz1", 64'(last_hz[1]), 64'd0);
      idle(2);

      // Flush masks the stall but counters keep running.
      step(1, 0, 0, 1, 1, 1, 7, 0, 0, 0, 3'b000, 0);
      step(1, 0, 1, 1, 1, 0, 8, 7, 0, 0, 3'b001, 0);
      chk("t5_flush_hz", 64'(last_hz[0]), 64'd0);
      chk("t5_flush_src", 64'(last_src0), 64'd1);
      step(1, 0, 0, 1, 0, 0, 0, 7, 0, 0, 3'b001, 0);
      chk("t5_after_flush", 64'(last_hz[0]), 64'd0);
      idle(4);

      // Async reset with r4 counting; then ignore_hazard and perf_clr.
      step(1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 3'b000, 0);
      async_reset();
      step(1, 0, 0, 1, 0, 0, 0, 4, 0, 0, 3'b001, 0);
      chk("t6_post_reset", 64'(last_hz[0]), 64'd0);
      step(1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 3'b000, 0);
      step(1, 1, 0, 1, 0, 0, 0, 4, 4, 4, 3'b111, 0);
      chk("t6_ignore_hz", 64'(last_hz[0]), 64'd0);
      chk("t6_ignore_src", 64'(last_src0), 64'd0);
      step(1, 0, 0, 1, 0, 0, 0, 4, 0, 0, 3'b001, 1);
      chk("t7_clr_hz", 64'(last_hz[0]), 64'd1);
      chk("t7_clr_wins", 64'(last_stall0), 64'd0);
      idle(3);

      // Random traffic on a few registers to provoke collisions and counter saturation.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 3'($urandom), $urandom_range(0, 31) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
